// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB master sequencer.
package apb_pkg;

    // Transfer phase of the APB master: idle, address setup, data access.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_AW       = 9;
    localparam int APB_DW       = 8;
    localparam int APB_MAX_WAIT = 15;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase. Counts stalled cycles and flags
// the cycle in which the count reaches MAX_WAIT so the master can abort.
module apb_wait_timer #(
    parameter  int MAX_WAIT = 15,
    localparam int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CW-1:0] count;

    // Count stalled cycles; clear wins so each new transfer starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Expire on the stalled cycle whose increment lands on MAX_WAIT.
    always_comb begin
        expire = enable && (count == CW'(MAX_WAIT - 1));
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: turns a request into an APB SETUP/ACCESS cycle,
// decodes the slave from the address MSB, captures read data and aborts
// transfers that stall past MAX_WAIT wait states.
//
// Handshake: a request is taken when transfer=1 while the master is IDLE or
// in the ACCESS cycle where pready=1; request fields are sampled only then.
// An ACCESS cycle completes on pready=1; xfer_done pulses for one cycle
// afterwards, with xfer_err set for pslverr or a timeout abort.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int AW       = APB_AW,
    parameter int DW       = APB_DW,
    parameter int MAX_WAIT = APB_MAX_WAIT
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out,
    output logic          xfer_done,
    output logic          xfer_err,
    output logic          psel1,
    output logic          psel2,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata1,
    input  logic [DW-1:0] prdata2,
    input  logic          pready,
    input  logic          pslverr,
    output apb_state_e    state
);

    apb_state_e state_next;
    logic       load_req;
    logic       complete;
    logic       timeout;
    logic       wait_clear;
    logic       wait_en;

    // Wait-state timer: restarted in SETUP, counts ACCESS cycles with pready low.
    always_comb begin
        wait_clear = (state == SETUP);
        wait_en    = (state == ACCESS) && !pready;
    end

    apb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (pclk),
        .rst_n  (presetn),
        .clear  (wait_clear),
        .enable (wait_en),
        .expire (timeout)
    );

    // State register; reset drops any in-flight transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the request-load and completion strobes.
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    state_next = SETUP;
                    load_req   = 1'b1;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    complete = 1'b1;
                    if (transfer) begin
                        state_next = SETUP;
                        load_req   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // APB control outputs decoded from state; the address MSB picks the slave.
    always_comb begin
        psel1   = (state != IDLE) && !paddr[AW-1];
        psel2   = (state != IDLE) &&  paddr[AW-1];
        penable = (state == ACCESS);
    end

    // Latch the request fields so they stay stable through SETUP and ACCESS.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (load_req) begin
            pwrite <= !read_write;
            paddr  <= read_write ? apb_read_paddr : apb_write_paddr;
            pwdata <= apb_write_data;
        end
    end

    // One-cycle completion pulse; a timeout always reports as an error.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            xfer_done <= complete || timeout;
            xfer_err  <= (complete && pslverr) || timeout;
        end
    end

    // Capture read data on any read completion (pslverr included), never on abort.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            apb_read_data_out <= '0;
        end else if (complete && !pwrite) begin
            apb_read_data_out <= paddr[AW-1] ? prdata2 : prdata1;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed vector table, hand-written
// back-to-back and reset sequences, then randomized transfers against a model.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int AW       = 9;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 15;

    logic          pclk;
    logic          presetn;
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_read_data_out;
    logic          xfer_done;
    logic          xfer_err;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;
    logic          pready;
    logic          pslverr;
    apb_state_e    state;

    apb_master_ctrl #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out),
        .xfer_done         (xfer_done),
        .xfer_err          (xfer_err),
        .psel1             (psel1),
        .psel2             (psel2),
        .penable           (penable),
        .pwrite            (pwrite),
        .paddr             (paddr),
        .pwdata            (pwdata),
        .prdata1           (prdata1),
        .prdata2           (prdata2),
        .pready            (pready),
        .pslverr           (pslverr),
        .state             (state)
    );

    // Clock and watchdog
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // One transfer: request, slave response and expected results.
    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
        logic          slverr;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          vecs[8];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] model_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_psel1"},   32'(psel1),   32'd0);
        check({tag, "_psel2"},   32'(psel2),   32'd0);
        check({tag, "_penable"}, 32'(penable), 32'd0);
        check({tag, "_state"},   32'(state),   32'(IDLE));
    endtask

    // Reference model: spec rules for error flag and read-data register.
    task automatic model_fill(inout vec_t v);
        bit timed_out;
        timed_out = (v.waits >= MAX_WAIT);
        v.exp_err = timed_out || v.slverr;
        if (v.rw && !timed_out) model_rdata = v.rdata;
        v.exp_rdata = model_rdata;
    endtask

    // Driver: run one isolated transfer and check every phase.
    task automatic run_xfer(input vec_t v, input string tag);
        logic        sel2;
        int          n_acc;
        logic [DW:0] e;
        sel2  = v.addr[AW-1];
        n_acc = (v.waits >= MAX_WAIT) ? MAX_WAIT : v.waits + 1;
        exp_q.push_back({v.exp_err, v.exp_rdata});

        @(negedge pclk);
        transfer       = 1'b1;
        read_write     = v.rw;
        apb_write_data = v.wdata;
        if (v.rw) begin
            apb_read_paddr  = v.addr;
            apb_write_paddr = AW'($urandom);
        end else begin
            apb_write_paddr = v.addr;
            apb_read_paddr  = AW'($urandom);
        end
        prdata1 = sel2 ? ~v.rdata : v.rdata;
        prdata2 = sel2 ? v.rdata : ~v.rdata;
        pready  = 1'b0;
        pslverr = 1'b0;

        @(posedge pclk);
        @(negedge pclk);
        transfer        = 1'b0;
        read_write      = ~v.rw;
        apb_write_paddr = AW'($urandom);
        apb_read_paddr  = AW'($urandom);
        apb_write_data  = DW'($urandom);
        pready          = 1'($urandom);
        check({tag, "_setup_state"},   32'(state),   32'(SETUP));
        check({tag, "_setup_psel1"},   32'(psel1),   32'(!sel2));
        check({tag, "_setup_psel2"},   32'(psel2),   32'(sel2));
        check({tag, "_setup_penable"}, 32'(penable), 32'd0);
        check({tag, "_pwrite"},        32'(pwrite),  32'(!v.rw));
        check({tag, "_paddr"},         32'(paddr),   32'(v.addr));
        check({tag, "_pwdata"},        32'(pwdata),  32'(v.wdata));

        @(posedge pclk);
        @(negedge pclk);
        check({tag, "_access_penable"}, 32'(penable), 32'd1);
        check({tag, "_access_psel"},    32'({psel2, psel1}), sel2 ? 32'd2 : 32'd1);

        for (int c = 0; c < n_acc; c++) begin
            pready  = (c == v.waits);
            pslverr = (c == v.waits) && v.slverr;
            @(posedge pclk);
            @(negedge pclk);
            if (c < n_acc - 1) begin
                check({tag, "_wait_penable"}, 32'(penable), 32'd1);
                check({tag, "_wait_done"},    32'(xfer_done), 32'd0);
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;

        check({tag, "_done"}, 32'(xfer_done), 32'd1);
        check_idle_outputs({tag, "_end"});
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_err"},   32'(xfer_err),          32'(e[DW]));
            check({tag, "_rdata"}, 32'(apb_read_data_out), 32'(e[DW-1:0]));
        end

        @(posedge pclk);
        @(negedge pclk);
        check({tag, "_done_pulse"}, 32'(xfer_done), 32'd0);
        check({tag, "_err_pulse"},  32'(xfer_err),  32'd0);
    endtask

    initial begin
        vec_t v;
        presetn         = 1'b0;
        transfer        = 1'b0;
        read_write      = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_read_paddr  = '0;
        prdata1         = '0;
        prdata2         = '0;
        pready          = 1'b0;
        pslverr         = 1'b0;
        model_rdata     = '0;

        // Reset state
        #1;
        check_idle_outputs("reset");
        check("reset_done",  32'(xfer_done),         32'd0);
        check("reset_err",   32'(xfer_err),          32'd0);
        check("reset_rdata", 32'(apb_read_data_out), 32'd0);
        check("reset_paddr", 32'(paddr),             32'd0);
        repeat (3) @(negedge pclk);
        presetn = 1'b1;

        // Directed vectors: rw, addr, wdata, rdata, waits, slverr, exp_err, exp_rdata
        vecs[0] = '{1'b0, 9'h005, 8'hA5, 8'h00, 0,  1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 9'h105, 8'h00, 8'h3C, 2,  1'b0, 1'b0, 8'h3C};
        vecs[2] = '{1'b1, 9'h0AA, 8'h00, 8'hEE, 20, 1'b0, 1'b1, 8'h3C};
        vecs[3] = '{1'b0, 9'h020, 8'h11, 8'h00, 0,  1'b1, 1'b1, 8'h3C};
        vecs[4] = '{1'b1, 9'h033, 8'h00, 8'h81, 0,  1'b0, 1'b0, 8'h81};
        vecs[5] = '{1'b1, 9'h1FF, 8'h00, 8'h42, 1,  1'b1, 1'b1, 8'h42};
        vecs[6] = '{1'b0, 9'h1C0, 8'h5F, 8'h00, 14, 1'b0, 1'b0, 8'h42};
        vecs[7] = '{1'b1, 9'h0F0, 8'h00, 8'h99, 15, 1'b0, 1'b1, 8'h42};
        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end
        model_rdata = 8'h42;

        // Back-to-back: write 0x010 then read 0x110 with transfer held high
        @(negedge pclk);
        transfer        = 1'b1;
        read_write      = 1'b0;
        apb_write_paddr = 9'h010;
        apb_write_data  = 8'h77;
        prdata1         = 8'hC3;
        prdata2         = 8'h5A;
        @(posedge pclk);
        @(negedge pclk);
        check("b2b_setup1_psel1", 32'(psel1), 32'd1);
        read_write     = 1'b1;
        apb_read_paddr = 9'h110;
        pready         = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check("b2b_access1_penable", 32'(penable), 32'd1);
        check("b2b_access1_pwrite",  32'(pwrite),  32'd1);
        @(posedge pclk);
        @(negedge pclk);
        transfer = 1'b0;
        check("b2b_done1",          32'(xfer_done), 32'd1);
        check("b2b_err1",           32'(xfer_err),  32'd0);
        check("b2b_setup2_state",   32'(state),     32'(SETUP));
        check("b2b_setup2_psel",    32'({psel2, psel1}), 32'd2);
        check("b2b_setup2_penable", 32'(penable),   32'd0);
        check("b2b_setup2_paddr",   32'(paddr),     32'h110);
        check("b2b_setup2_pwrite",  32'(pwrite),    32'd0);
        @(posedge pclk);
        @(negedge pclk);
        check("b2b_access2_penable", 32'(penable),   32'd1);
        check("b2b_access2_done",    32'(xfer_done), 32'd0);
        @(posedge pclk);
        @(negedge pclk);
        pready = 1'b0;
        check("b2b_done2",  32'(xfer_done),         32'd1);
        check("b2b_rdata2", 32'(apb_read_data_out), 32'h5A);
        check_idle_outputs("b2b_end");
        model_rdata = 8'h5A;

        // Reset in the middle of a stalled read
        @(negedge pclk);
        transfer       = 1'b1;
        read_write     = 1'b1;
        apb_read_paddr = 9'h105;
        @(posedge pclk);
        @(negedge pclk);
        transfer = 1'b0;
        @(posedge pclk);
        @(posedge pclk);
        #2;
        check("rst_mid_penable_before", 32'(penable), 32'd1);
        presetn = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid_done",   32'(xfer_done),         32'd0);
        check("rst_mid_rdata",  32'(apb_read_data_out), 32'd0);
        check("rst_mid_paddr",  32'(paddr),             32'd0);
        check("rst_mid_pwdata", 32'(pwdata),            32'd0);
        check("rst_mid_pwrite", 32'(pwrite),            32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check("rst_mid_no_done", 32'(xfer_done), 32'd0);
        model_rdata = '0;
        v = '{1'b1, 9'h0C3, 8'h00, 8'h6D, 1, 1'b0, 1'b0, 8'h00};
        model_fill(v);
        run_xfer(v, "post_rst");

        // Randomized transfers against the reference model
        for (int i = 0; i < 30; i++) begin
            v.rw     = 1'($urandom);
            v.addr   = AW'($urandom);
            v.wdata  = DW'($urandom);
            v.rdata  = DW'($urandom);
            v.waits  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 17) : $urandom_range(0, 2);
            v.slverr = ($urandom_range(0, 3) == 0);
            model_fill(v);
            run_xfer(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
